// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants.
//   ADDR_W / DATA_W  : default address and instruction widths
//   START_ADDR       : default fetch PC after reset
//   WORD_SIZE        : default PC increment in bytes and memory access size
//   count_width()    : bits needed to hold a count of 0..n inclusive
package cpu_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam logic [31:0] START_ADDR = 32'h8002_0000;
  localparam int unsigned WORD_SIZE  = 4;

  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used twice by the prefetcher: once to remember the
// addresses of accepted requests, once as the instruction queue.
//   clock, reset_n : clock and asynchronous active-low reset
//   push/push_data : write one entry (ignored when full unless popping too)
//   pop            : drop the head entry (ignored when empty)
//   flush          : empty the FIFO; takes precedence over push and pop
//   pop_data       : current head entry (valid when count != 0)
//   count          : number of stored entries, 0..DEPTH
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  input  logic                           flush,
  output logic [WIDTH-1:0]               pop_data,
  output logic [count_width(DEPTH)-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and leaving it out keeps it a plain register file/RAM.
  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of block order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: issues sequential word reads from the fetch PC,
// pairs each in-order response with the address that requested it and
// queues them for the decoder. A redirect reloads the PC, flushes the queue
// and discards every response still in flight.
//   clock, reset_n              : clock, asynchronous active-low reset
//   enable_fetch                : allow new memory requests
//   stall                       : consumer not accepting the head instruction
//   redirect_valid, redirect_pc : branch/jump redirect strobe and target
//   mem_req, mem_addr, mem_rw,
//   mem_access_size, mem_ready  : request channel (read-only, WORD_SIZE bytes)
//   mem_rvalid, mem_rdata       : in-order response channel
//   inst_valid, inst_pc,
//   inst_data                   : head of the instruction queue
module fetch_prefetch #(
  parameter int unsigned        ADDR_W     = cpu_pkg::ADDR_W,
  parameter int unsigned        DATA_W     = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]  START_ADDR = ADDR_W'(cpu_pkg::START_ADDR),
  parameter int unsigned        WORD_SIZE  = cpu_pkg::WORD_SIZE,
  parameter int unsigned        DEPTH      = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable_fetch,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [31:0]       mem_access_size,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [DATA_W-1:0] inst_data
);

  localparam int unsigned CNT_W   = cpu_pkg::count_width(DEPTH);
  localparam int unsigned OCC_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  logic [ADDR_W-1:0]  fetch_pc;
  // outstanding counts every request in flight, including those already
  // condemned by a redirect; drop_cnt says how many of the oldest to discard.
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   outstanding_next;
  logic [CNT_W-1:0]   drop_cnt;
  logic [CNT_W-1:0]   addr_count;
  logic [CNT_W-1:0]   queue_count;
  logic [OCC_W-1:0]   occupancy;
  logic               handshake;
  logic               drop_resp;
  logic               live_resp;
  logic               queue_push;
  logic               queue_pop;
  logic [ADDR_W-1:0]  resp_addr;
  logic [ENTRY_W-1:0] head_entry;

  assign mem_rw          = 1'b1;
  assign mem_access_size = 32'(WORD_SIZE);
  assign mem_addr        = fetch_pc;
  assign inst_valid      = (queue_count != '0);
  assign {inst_pc, inst_data} = head_entry;

  // NOTE: every signal driven here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    // Reserving a queue slot per request in flight guarantees pushes never
    // overflow the instruction queue.
    occupancy  = {1'b0, queue_count} + {1'b0, outstanding};
    mem_req    = enable_fetch && !redirect_valid && (occupancy < OCC_W'(DEPTH));
    handshake  = mem_req && mem_ready;
    drop_resp  = mem_rvalid && (drop_cnt != '0);
    // A response with nothing tracked (e.g. stale after reset) is ignored.
    live_resp  = mem_rvalid && (drop_cnt == '0) && (addr_count != '0);
    queue_push = live_resp && !redirect_valid;
    queue_pop  = inst_valid && !stall && !redirect_valid;
    outstanding_next = outstanding + CNT_W'(handshake)
                     - CNT_W'(drop_resp || live_resp);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= START_ADDR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        // Everything still in flight after this cycle's response is stale.
        drop_cnt <= outstanding_next;
      end else begin
        if (handshake) fetch_pc <= fetch_pc + ADDR_W'(WORD_SIZE);
        if (drop_resp) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_addr_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (handshake),
    .push_data (fetch_pc),
    .pop       (live_resp),
    .flush     (redirect_valid),
    .pop_data  (resp_addr),
    .count     (addr_count)
  );

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (queue_push),
    .push_data ({resp_addr, mem_rdata}),
    .pop       (queue_pop),
    .flush     (redirect_valid),
    .pop_data  (head_entry),
    .count     (queue_count)
  );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch. A behavioural memory serves
// accepted requests in order with random latency; the reference model only
// knows program order: issued addresses and consumed instructions must follow
// the PC sequence, restarting at each redirect target.
module tb_fetch_prefetch;

  localparam logic [31:0] START = 32'h8002_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable_fetch = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rw;
  logic [31:0] mem_access_size;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  always #5 clock = ~clock;

  fetch_prefetch #(.DEPTH(4)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable_fetch    (enable_fetch),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_rw          (mem_rw),
    .mem_access_size (mem_access_size),
    .mem_ready       (mem_ready),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .inst_valid      (inst_valid),
    .inst_pc         (inst_pc),
    .inst_data       (inst_data)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pending[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          n_pops = 0;

  bit          drv_enable, drv_stall, drv_redirect, drv_ready, mem_hold;
  logic [31:0] drv_target;
  int          resp_prob;

  logic [31:0] exp_addr, exp_pc;
  bit          prev_valid, prev_stall, prev_redirect;
  logic [31:0] prev_ipc, prev_idata;

  bit          o_req, o_hs, o_ivalid, o_pop;
  logic [31:0] o_addr, o_ipc, o_idata;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: drive inputs, run the memory, observe, check the model.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    enable_fetch   = drv_enable;
    stall          = drv_stall;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_target;
    mem_ready      = drv_ready;
    if (!mem_hold && pending.size() != 0 && pending[0].due <= cyc &&
        int'($urandom_range(99)) < resp_prob) begin
      mem_rvalid = 1'b1;
      mem_rdata  = inst_of(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    #1;
    o_req    = mem_req;
    o_addr   = mem_addr;
    o_ivalid = inst_valid;
    o_ipc    = inst_pc;
    o_idata  = inst_data;
    o_hs     = o_req && drv_ready;
    o_pop    = o_ivalid && !drv_stall && !drv_redirect;

    n_cmp++;
    if (mem_rw !== 1'b1 || mem_access_size !== 32'd4) begin
      n_bad++;
      $display("FAIL const_outputs cyc=%0d: rw=%b size=%0d, want rw=1 size=4", cyc, mem_rw, mem_access_size);
    end
    n_cmp++;
    if (o_req && (drv_redirect || !drv_enable)) begin
      n_bad++;
      $display("FAIL issue_gate cyc=%0d: mem_req=1 with enable=%b redirect=%b", cyc, drv_enable, drv_redirect);
    end
    if (o_hs) begin
      n_cmp++;
      if (o_addr !== exp_addr) begin
        n_bad++;
        $display("FAIL fetch_addr cyc=%0d: got %h want %h", cyc, o_addr, exp_addr);
      end
      pending.push_back('{addr: o_addr, due: cyc + 1});
      exp_addr += 32'd4;
    end
    if (prev_valid && prev_stall && !prev_redirect) begin
      n_cmp++;
      if (!o_ivalid || o_ipc !== prev_ipc || o_idata !== prev_idata) begin
        n_bad++;
        $display("FAIL stall_hold cyc=%0d: valid=%b pc=%h data=%h want pc=%h data=%h",
                 cyc, o_ivalid, o_ipc, o_idata, prev_ipc, prev_idata);
      end
    end
    if (o_pop) begin
      n_cmp++;
      n_pops++;
      if (o_ipc !== exp_pc || o_idata !== inst_of(exp_pc)) begin
        n_bad++;
        $display("FAIL inst_order cyc=%0d: pc=%h data=%h want pc=%h data=%h",
                 cyc, o_ipc, o_idata, exp_pc, inst_of(exp_pc));
      end
      exp_pc += 32'd4;
    end
    if (drv_redirect) begin
      exp_addr = drv_target;
      exp_pc   = drv_target;
    end
    prev_valid    = o_ivalid;
    prev_stall    = drv_stall;
    prev_redirect = drv_redirect;
    prev_ipc      = o_ipc;
    prev_idata    = o_idata;
  endtask

  task automatic do_reset(input bit keep_stale);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    enable_fetch = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    drv_enable = 0; drv_stall = 0; drv_redirect = 0; drv_ready = 0; mem_hold = 0;
    drv_target = '0; resp_prob = 100;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== START ||
        mem_rw !== 1'b1 || mem_access_size !== 32'd4) begin
      n_bad++;
      $display("FAIL reset_async: valid=%b req=%b addr=%h rw=%b size=%0d want 0 0 %h 1 4",
               inst_valid, mem_req, mem_addr, mem_rw, mem_access_size, START);
    end
    if (!keep_stale) pending.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_addr = START; exp_pc = START;
    prev_valid = 0; prev_stall = 0; prev_redirect = 0;
  endtask

  task automatic test_reset();
    do_reset(0);
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0 || mem_addr !== START || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: valid=%b addr=%h req=%b want 0 %h 0", inst_valid, mem_addr, mem_req, START);
    end
    repeat (2) step();
    n_cmp++;
    if (o_ivalid !== 1'b0 || o_req !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: valid=%b req=%b want 0 0", o_ivalid, o_req);
    end
  endtask

  task automatic test_sequential();
    int hs_cyc = -1;
    int v_cyc = -1;
    int nh = 0;
    do_reset(0);
    drv_enable = 1; drv_ready = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (o_hs && nh < 3) begin
        n_cmp++;
        if (o_addr !== START + 32'(4 * nh)) begin
          n_bad++;
          $display("FAIL seq_addr[%0d]: got %h want %h", nh, o_addr, START + 32'(4 * nh));
        end
        nh++;
      end
      if (o_hs && hs_cyc < 0) hs_cyc = cyc;
      if (o_ivalid && v_cyc < 0) v_cyc = cyc;
    end
    n_cmp++;
    if (hs_cyc < 0 || v_cyc - hs_cyc != 2) begin
      n_bad++;
      $display("FAIL first_latency: got %0d cycles want 2", v_cyc - hs_cyc);
    end
  endtask

  task automatic test_stall();
    int nh = 0;
    int pops0;
    do_reset(0);
    drv_enable = 1; drv_ready = 1; drv_stall = 1;
    repeat (6) begin
      step();
      if (o_hs) nh++;
      if (o_ivalid) begin
        n_cmp++;
        if (o_ipc !== START) begin
          n_bad++;
          $display("FAIL stall_head: got %h want %h", o_ipc, START);
        end
      end
    end
    n_cmp++;
    if (nh != 4 || o_req !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_fill: handshakes=%0d req=%b want 4 0", nh, o_req);
    end
    drv_stall = 0;
    pops0 = n_pops;
    repeat (12) step();
    n_cmp++;
    if (n_pops - pops0 < 4) begin
      n_bad++;
      $display("FAIL stall_drain: pops=%0d want >=4", n_pops - pops0);
    end
  endtask

  task automatic test_not_ready();
    do_reset(0);
    drv_enable = 1; drv_ready = 1;
    repeat (2) step();
    drv_ready = 0;
    repeat (3) begin
      step();
      n_cmp++;
      if (o_req !== 1'b1 || o_addr !== START + 32'd8) begin
        n_bad++;
        $display("FAIL not_ready_hold: req=%b addr=%h want 1 %h", o_req, o_addr, START + 32'd8);
      end
    end
    drv_ready = 1;
    step();
    n_cmp++;
    if (!o_hs || o_addr !== START + 32'd8) begin
      n_bad++;
      $display("FAIL ready_accept: hs=%b addr=%h want 1 %h", o_hs, o_addr, START + 32'd8);
    end
    step();
    n_cmp++;
    if (o_addr !== START + 32'd12) begin
      n_bad++;
      $display("FAIL ready_advance: addr=%h want %h", o_addr, START + 32'd12);
    end
  endtask

  // Steps until the head is valid and checks it is the expected PC.
  task automatic expect_first_valid(input logic [31:0] want, input string name);
    bit seen = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      step();
      if (o_ivalid) seen = 1;
    end
    n_cmp++;
    if (!seen || o_ipc !== want) begin
      n_bad++;
      $display("FAIL %s: seen=%b pc=%h want %h", name, seen, o_ipc, want);
    end
  endtask

  task automatic test_redirect();
    do_reset(0);
    drv_enable = 1; drv_ready = 1; mem_hold = 1;
    repeat (2) step();
    drv_redirect = 1; drv_target = 32'h8003_0000;
    step();
    drv_redirect = 0; mem_hold = 0;
    expect_first_valid(32'h8003_0000, "redirect_first");
  endtask

  task automatic test_back_to_back();
    do_reset(0);
    drv_enable = 1; drv_ready = 1; mem_hold = 1;
    repeat (3) step();
    mem_hold = 0;
    drv_redirect = 1; drv_target = 32'h8004_0000;
    step();
    drv_target = 32'h8005_0000;
    step();
    drv_redirect = 0;
    expect_first_valid(32'h8005_0000, "b2b_redirect_first");
  endtask

  task automatic test_wrap();
    int nh = 0;
    do_reset(0);
    drv_enable = 1; drv_ready = 1;
    drv_redirect = 1; drv_target = 32'hFFFF_FFFC;
    step();
    drv_redirect = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_hs && nh < 2) begin
        n_cmp++;
        if (o_addr !== 32'hFFFF_FFFC + 32'(4 * nh)) begin
          n_bad++;
          $display("FAIL wrap_addr[%0d]: got %h want %h", nh, o_addr, 32'hFFFF_FFFC + 32'(4 * nh));
        end
        nh++;
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset(0);
    drv_enable = 1; drv_ready = 1; mem_hold = 1;
    repeat (3) step();
    do_reset(1);
    mem_hold = 0;
    repeat (3) begin
      step();
      n_cmp++;
      if (o_ivalid !== 1'b0) begin
        n_bad++;
        $display("FAIL stale_ignored: valid=%b pc=%h want valid 0", o_ivalid, o_ipc);
      end
    end
    drv_enable = 1; drv_ready = 1;
    expect_first_valid(START, "post_reset_first");
  endtask

  task automatic test_random();
    int pops0 = n_pops;
    do_reset(0);
    for (int i = 0; i < 3000; i++) begin
      drv_enable   = ($urandom_range(99) < 85);
      drv_stall    = ($urandom_range(99) < 30);
      drv_ready    = ($urandom_range(99) < 70);
      drv_redirect = ($urandom_range(99) < 3);
      drv_target   = $urandom & 32'hFFFF_FFFC;
      resp_prob    = 60;
      step();
    end
    n_cmp++;
    if (n_pops - pops0 < 200) begin
      n_bad++;
      $display("FAIL random_progress: pops=%0d want >=200", n_pops - pops0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_not_ready();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
